// File: rtl/difftest_pkg.sv
// Shared types and widths for the difftest commit queue: the packed entry layout
// presented on out_entry and the counter widths used by the queue.
package difftest_pkg;

    localparam int COREID_W  = 8;
    localparam int SEQ_W     = 32;
    localparam int PC_W      = 64;
    localparam int INSTR_W   = 32;
    localparam int ROB_W     = 10;
    localparam int WDEST_W   = 8;
    localparam int DROP_W    = 16;
    localparam int INSTRET_W = 64;
    localparam int ENTRY_W   = COREID_W + SEQ_W + PC_W + INSTR_W + ROB_W + WDEST_W + 4;

    typedef struct packed {
        logic [COREID_W-1:0] coreid;
        logic [SEQ_W-1:0]    seq;
        logic [PC_W-1:0]     pc;
        logic [INSTR_W-1:0]  instr;
        logic [ROB_W-1:0]    robIdx;
        logic [WDEST_W-1:0]  wdest;
        logic                rfwen;
        logic                fpwen;
        logic                isRVC;
        logic                skip;
    } entry_t;

endpackage

// File: rtl/difftest_commit_compact.sv
// Channel compaction: for each channel, the number of valid channels below it
// (its slot offset from the write pointer), plus the total valid count.
module difftest_commit_compact #(
    parameter int NUM_CH = 6,
    parameter int CNT_W  = $clog2(NUM_CH + 1)
) (
    input  logic [NUM_CH-1:0]            i_valid,
    output logic [NUM_CH-1:0][CNT_W-1:0] o_offset,
    output logic [CNT_W-1:0]             o_total
);

    logic [CNT_W-1:0] w_run;

    always_comb begin
        w_run    = '0;
        o_offset = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            o_offset[ch] = w_run;
            w_run        = w_run + CNT_W'(i_valid[ch]);
        end
        o_total = w_run;
    end

endmodule

// File: rtl/difftest_commit_queue.sv
// Multi-channel commit queue: compacts up to NUM_CH commits per cycle into a
// circular buffer, stamps sequence numbers, and drains one entry per cycle.
module difftest_commit_queue
    import difftest_pkg::*;
#(
    parameter int         NUM_CH  = 6,
    parameter int         DEPTH   = 32,
    parameter logic [7:0] CORE_ID = 8'd0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH-1:0]        in_skip,
    input  logic [NUM_CH-1:0]        in_isRVC,
    input  logic [NUM_CH-1:0]        in_rfwen,
    input  logic [NUM_CH-1:0]        in_fpwen,
    input  logic [8*NUM_CH-1:0]      in_wdest,
    input  logic [10*NUM_CH-1:0]     in_robIdx,
    input  logic [64*NUM_CH-1:0]     in_pc,
    input  logic [32*NUM_CH-1:0]     in_instr,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ENTRY_W-1:0]       out_entry,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_count,
    output logic [INSTRET_W-1:0]     instret
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int CNT_W = $clog2(NUM_CH + 1);

    function automatic logic [DROP_W-1:0] sat_add_drop(input logic [DROP_W-1:0] a,
                                                        input logic [CNT_W-1:0]  b);
        logic [DROP_W:0] s;
        s = {1'b0, a} + (DROP_W + 1)'(b);
        return s[DROP_W] ? {DROP_W{1'b1}} : s[DROP_W-1:0];
    endfunction

    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [OCC_W-1:0]     r_occ;
    logic [SEQ_W-1:0]     r_seq;
    logic                 r_overflow;
    logic [DROP_W-1:0]    r_drop;
    logic [INSTRET_W-1:0] r_instret;
    entry_t               r_mem [DEPTH];

    logic [NUM_CH-1:0][CNT_W-1:0] w_offset;
    logic [CNT_W-1:0]             w_total;
    logic [OCC_W-1:0]             w_free;
    logic                         w_ready;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_drop;
    logic [CNT_W-1:0]             w_npush;
    entry_t                       w_ent  [NUM_CH];
    logic [PTR_W-1:0]             w_widx [NUM_CH];

    difftest_commit_compact #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) u_compact (
        .i_valid  (in_valid),
        .o_offset (w_offset),
        .o_total  (w_total)
    );

    // Admission looks only at registered occupancy, so a same-cycle pop never helps.
    assign w_free  = OCC_W'(DEPTH) - r_occ;
    assign w_ready = (w_free >= OCC_W'(NUM_CH));
    assign w_push  = enable & w_ready;
    assign w_npush = w_push ? w_total : '0;
    assign w_pop   = (r_occ != '0) & out_ready;
    assign w_drop  = enable & ~w_ready & (w_total != '0);

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_widx[ch] = r_wptr + PTR_W'(w_offset[ch]);
            w_ent[ch]  = '{coreid: CORE_ID,
                           seq:    r_seq + SEQ_W'(w_offset[ch]),
                           pc:     in_pc[64*ch +: 64],
                           instr:  in_instr[32*ch +: 32],
                           robIdx: in_robIdx[10*ch +: 10],
                           wdest:  in_wdest[8*ch +: 8],
                           rfwen:  in_rfwen[ch],
                           fpwen:  in_fpwen[ch],
                           isRVC:  in_isRVC[ch],
                           skip:   in_skip[ch]};
        end
    end

    // Payload storage is not reset; occupancy alone decides what is live.
    always_ff @(posedge clock) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (w_push && in_valid[ch]) begin
                r_mem[w_widx[ch]] <= w_ent[ch];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_occ      <= '0;
            r_seq      <= '0;
            r_overflow <= 1'b0;
            r_drop     <= '0;
            r_instret  <= '0;
        end else begin
            r_wptr    <= r_wptr + PTR_W'(w_npush);
            r_rptr    <= r_rptr + PTR_W'(w_pop);
            r_occ     <= r_occ + OCC_W'(w_npush) - OCC_W'(w_pop);
            r_seq     <= r_seq + SEQ_W'(w_npush);
            r_instret <= r_instret + INSTRET_W'(w_npush);
            if (w_drop) begin
                r_overflow <= 1'b1;
                r_drop     <= sat_add_drop(r_drop, w_total);
            end
        end
    end

    assign in_ready   = w_ready;
    assign out_valid  = (r_occ != '0);
    assign out_entry  = r_mem[r_rptr];
    assign overflow   = r_overflow;
    assign drop_count = r_drop;
    assign instret    = r_instret;

endmodule

// File: tb/tb_difftest_commit_queue.sv
// Randomized scoreboard bench for difftest_commit_queue with a queue-based reference model.
module tb_difftest_commit_queue;
    import difftest_pkg::*;

    localparam int         NUM_CH  = 6;
    localparam int         DEPTH   = 32;
    localparam logic [7:0] CORE_ID = 8'h5A;

    logic                  clock     = 1'b0;
    logic                  reset     = 1'b0;
    logic                  enable    = 1'b0;
    logic                  out_ready = 1'b0;
    logic [NUM_CH-1:0]     in_valid  = '0;
    logic [NUM_CH-1:0]     in_skip   = '0;
    logic [NUM_CH-1:0]     in_isRVC  = '0;
    logic [NUM_CH-1:0]     in_rfwen  = '0;
    logic [NUM_CH-1:0]     in_fpwen  = '0;
    logic [8*NUM_CH-1:0]   in_wdest  = '0;
    logic [10*NUM_CH-1:0]  in_robIdx = '0;
    logic [64*NUM_CH-1:0]  in_pc     = '0;
    logic [32*NUM_CH-1:0]  in_instr  = '0;
    logic                  in_ready;
    logic                  out_valid;
    logic [ENTRY_W-1:0]    out_entry;
    logic                  overflow;
    logic [15:0]           drop_count;
    logic [63:0]           instret;

    difftest_commit_queue #(
        .NUM_CH  (NUM_CH),
        .DEPTH   (DEPTH),
        .CORE_ID (CORE_ID)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_skip    (in_skip),
        .in_isRVC   (in_isRVC),
        .in_rfwen   (in_rfwen),
        .in_fpwen   (in_fpwen),
        .in_wdest   (in_wdest),
        .in_robIdx  (in_robIdx),
        .in_pc      (in_pc),
        .in_instr   (in_instr),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_entry  (out_entry),
        .overflow   (overflow),
        .drop_count (drop_count),
        .instret    (instret)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    function automatic void check(input string nm, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Reference model: a list of committed-but-not-consumed entries plus counters.
    entry_t      exp_q[$];
    int          m_occ     = 0;
    logic [31:0] m_seq     = '0;
    logic [63:0] m_instret = '0;
    int          m_drop    = 0;
    bit          m_ovf     = 1'b0;

    always @(posedge clock or negedge reset) begin
        int     n;
        int     pushed;
        bit     pop;
        entry_t e;
        if (!reset) begin
            exp_q.delete();
            m_occ = 0; m_seq = '0; m_instret = '0; m_drop = 0; m_ovf = 1'b0;
        end else begin
            n = $countones(in_valid);
            pushed = 0;
            pop = (m_occ != 0) && out_ready;
            if (enable) begin
                if (DEPTH - m_occ >= NUM_CH) begin
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        if (in_valid[ch]) begin
                            e = '{coreid: CORE_ID, seq: m_seq, pc: in_pc[64*ch +: 64],
                                  instr: in_instr[32*ch +: 32], robIdx: in_robIdx[10*ch +: 10],
                                  wdest: in_wdest[8*ch +: 8], rfwen: in_rfwen[ch],
                                  fpwen: in_fpwen[ch], isRVC: in_isRVC[ch], skip: in_skip[ch]};
                            exp_q.push_back(e);
                            m_seq = m_seq + 32'd1;
                        end
                    end
                    pushed = n;
                    m_instret = m_instret + 64'(n);
                end else if (n > 0) begin
                    m_ovf = 1'b1;
                    m_drop = (m_drop + n > 65535) ? 65535 : m_drop + n;
                end
            end
            m_occ = m_occ + pushed - (pop ? 1 : 0);
        end
    end

    // Monitor: compares DUT status and head entry each cycle, consumes on handshake.
    always @(negedge clock) begin
        if (reset) begin
            check("out_valid", 160'(out_valid), 160'(m_occ != 0));
            check("in_ready", 160'(in_ready), 160'(DEPTH - m_occ >= NUM_CH));
            check("overflow", 160'(overflow), 160'(m_ovf));
            check("drop_count", 160'(drop_count), 160'(m_drop));
            check("instret", 160'(instret), 160'(m_instret));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL head: got unexpected entry %0h expected none", out_entry);
                end else begin
                    check("head_entry", 160'(out_entry), 160'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rand_payload();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            in_pc[64*ch +: 64]    = {$urandom, $urandom};
            in_instr[32*ch +: 32] = $urandom;
            in_robIdx[10*ch +: 10] = 10'($urandom);
            in_wdest[8*ch +: 8]   = 8'($urandom);
        end
        in_skip  = NUM_CH'($urandom);
        in_isRVC = NUM_CH'($urandom);
        in_rfwen = NUM_CH'($urandom);
        in_fpwen = NUM_CH'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b0; enable = 1'b0; in_valid = '0; out_ready = 1'b0;
        step(); step();
        reset = 1'b1;
    endtask

    entry_t e;

    initial begin
        // Reset state
        do_reset();
        check("rst_out_valid", 160'(out_valid), 160'(0));
        check("rst_in_ready", 160'(in_ready), 160'(1));
        check("rst_overflow", 160'(overflow), 160'(0));
        check("rst_drop", 160'(drop_count), 160'(0));
        check("rst_instret", 160'(instret), 160'(0));

        // Single push on channel 0
        enable = 1'b1; rand_payload();
        in_valid = 6'b000001; in_pc[63:0] = 64'h8000_0000;
        step();
        in_valid = '0;
        e = entry_t'(out_entry);
        check("single_valid", 160'(out_valid), 160'(1));
        check("single_pc", 160'(e.pc), 160'(64'h8000_0000));
        check("single_seq", 160'(e.seq), 160'(0));
        check("single_core", 160'(e.coreid), 160'(CORE_ID));
        check("single_instret", 160'(instret), 160'(1));
        out_ready = 1'b1; step(); step();

        // Compaction of sparse channels
        do_reset(); enable = 1'b1; rand_payload();
        in_valid = 6'b101010;
        in_pc[64*1 +: 64] = 64'h10; in_pc[64*3 +: 64] = 64'h20; in_pc[64*5 +: 64] = 64'h30;
        step();
        in_valid = '0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            e = entry_t'(out_entry);
            check("compact_pc", 160'(e.pc), 160'(64'h10 * (k + 1)));
            check("compact_seq", 160'(e.seq), 160'(k));
            step();
        end
        check("compact_empty", 160'(out_valid), 160'(0));

        // Fill to capacity, then drop a group
        do_reset(); enable = 1'b1; out_ready = 1'b0; in_valid = '1;
        for (int g = 0; g < 5; g++) begin rand_payload(); step(); end
        check("full_in_ready", 160'(in_ready), 160'(0));
        rand_payload(); step();
        in_valid = '0;
        check("full_overflow", 160'(overflow), 160'(1));
        check("full_drop", 160'(drop_count), 160'(6));
        check("full_instret", 160'(instret), 160'(30));
        out_ready = 1'b1;
        repeat (34) step();

        // Occupancy 27 with a same-cycle pop: group still rejected
        do_reset(); enable = 1'b1; out_ready = 1'b0; in_valid = '1;
        for (int g = 0; g < 4; g++) begin rand_payload(); step(); end
        in_valid = 6'b000111; rand_payload(); step();
        check("sim_in_ready27", 160'(in_ready), 160'(0));
        in_valid = '1; out_ready = 1'b1; rand_payload(); step();
        in_valid = '0; out_ready = 1'b0;
        check("sim_in_ready26", 160'(in_ready), 160'(1));
        check("sim_drop", 160'(drop_count), 160'(6));
        check("sim_instret", 160'(instret), 160'(27));
        out_ready = 1'b1;
        repeat (30) step();

        // Long single-channel stream through the wrap point
        do_reset(); enable = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            rand_payload();
            in_valid = NUM_CH'(1) << $urandom_range(0, NUM_CH - 1);
            step();
        end
        in_valid = '0;
        repeat (3) step();
        check("wrap_drop", 160'(drop_count), 160'(0));
        check("wrap_instret", 160'(instret), 160'(100));

        // Reset in the middle of a stream
        do_reset(); enable = 1'b1; out_ready = 1'b0;
        in_valid = '1; rand_payload(); step();
        in_valid = 6'b001111; rand_payload(); step();
        in_valid = '0;
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 160'(out_valid), 160'(0));
        check("midrst_in_ready", 160'(in_ready), 160'(1));
        check("midrst_instret", 160'(instret), 160'(0));
        step();
        reset = 1'b1;
        in_valid = 6'b000100; rand_payload(); step();
        in_valid = '0;
        e = entry_t'(out_entry);
        check("midrst_seq", 160'(e.seq), 160'(0));
        check("midrst_instret1", 160'(instret), 160'(1));
        out_ready = 1'b1; step();

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            rand_payload();
            enable    = ($urandom_range(0, 9) != 0);
            in_valid  = NUM_CH'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = '0; out_ready = 1'b1;
        repeat (40) step();
        check("drained", 160'(exp_q.size()), 160'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
